// File: rtl/pcs_rx_dec.sv
// pcs_rx_dec: 10GBASE-R 64b/66b receive block decoder and DATA_W slice serializer feeding eth_rx.
// Optional build macro PCS_RX_DEC_ERR_CNT_EN adds a saturating error-block counter on err_cnt_o.

module pcs_rx_dec_slice #(
  parameter int KEEP_W      = 2,
  parameter int LANE0_CNT_N = 1
) (
  input  logic [KEEP_W-1:0]      ln_ctrl,
  input  logic [KEEP_W-1:0]      ln_idle,
  input  logic [KEEP_W-1:0]      ln_start,
  input  logic [KEEP_W-1:0]      ln_term,
  input  logic [KEEP_W-1:0]      ln_cancel,
  output logic                   ctrl_v,
  output logic                   idle,
  output logic [LANE0_CNT_N-1:0] start,
  output logic                   term,
  output logic [KEEP_W-1:0]      keep,
  output logic                   cancel
);
  assign ctrl_v = |ln_ctrl;
  assign idle   = &ln_idle;
  assign term   = |ln_term;
  assign cancel = |ln_cancel;
  // Data lanes of a terminate slice always sit below the /T/ lane, so the mask is LSB-packed.
  assign keep   = term ? ~ln_ctrl : '0;

  generate
    if (LANE0_CNT_N == 2) begin : g_two
      assign start = {ln_start[4], ln_start[0]};
    end else begin : g_one
      assign start = |ln_start;
    end
  endgenerate
endmodule

module pcs_rx_dec #(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LANE0_CNT_N = (DATA_W == 64) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [1:0]             blk_sync_i,
  input  logic [63:0]            blk_data_i,
  output logic                   mac_valid_o,
  output logic                   mac_cancel_o,
  output logic [DATA_W-1:0]      mac_data_o,
  output logic                   mac_ctrl_v_o,
  output logic                   mac_idle_o,
  output logic [LANE0_CNT_N-1:0] mac_start_o,
  output logic                   mac_term_o,
  output logic [KEEP_W-1:0]      mac_term_keep_o
`ifdef PCS_RX_DEC_ERR_CNT_EN
  ,
  output logic [15:0]            err_cnt_o
`endif
);
  localparam int SLICE_N = 64 / DATA_W;
  localparam int IDX_W   = (SLICE_N > 1) ? $clog2(SLICE_N) : 1;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'h55;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERR   = 8'hFE;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;
  typedef enum logic [2:0] {BK_DATA, BK_IDLE, BK_START0, BK_START4, BK_TERM, BK_ERR} blk_t;

  state_t state, state_nxt, dec_state;
  blk_t   blk;
  logic [2:0]  term_k;
  logic        is_err;
  logic        accept;
  logic        last;
  logic [IDX_W-1:0] idx, idx_nxt;

  logic [7:0][7:0] oct, ln_byte;
  logic [63:0]     tail;
  logic [7:0]      ln_ctrl, ln_idle, ln_start, ln_term, ln_cancel;

  assign oct  = blk_data_i;
  assign tail = {8'h00, blk_data_i[63:8]};

  always_comb begin
    blk    = BK_ERR;
    term_k = '0;
    if (blk_sync_i == 2'b01) begin
      blk = BK_DATA;
    end else if (blk_sync_i == 2'b10) begin
      case (oct[0])
        8'h1E:   blk = BK_IDLE;
        8'h78:   blk = BK_START0;
        8'h33:   blk = BK_START4;
        8'h87:   begin blk = BK_TERM; term_k = 3'd0; end
        8'h99:   begin blk = BK_TERM; term_k = 3'd1; end
        8'hAA:   begin blk = BK_TERM; term_k = 3'd2; end
        8'hB4:   begin blk = BK_TERM; term_k = 3'd3; end
        8'hCC:   begin blk = BK_TERM; term_k = 3'd4; end
        8'hD2:   begin blk = BK_TERM; term_k = 3'd5; end
        8'hE1:   begin blk = BK_TERM; term_k = 3'd6; end
        8'hFF:   begin blk = BK_TERM; term_k = 3'd7; end
        default: blk = BK_ERR;
      endcase
    end
  end

  // Lane view of the block given the frame state; a terminate outside a frame counts as an error.
  always_comb begin
    ln_byte   = oct;
    ln_ctrl   = '0;
    ln_idle   = '0;
    ln_start  = '0;
    ln_term   = '0;
    ln_cancel = '0;
    is_err    = 1'b0;
    dec_state = state;
    case (blk)
      BK_DATA: begin
        if (state == ST_IDLE) is_err = 1'b1;
      end
      BK_IDLE: begin
        ln_byte = {8{CH_IDLE}};
        ln_ctrl = '1;
        ln_idle = '1;
      end
      BK_START0: begin
        if (state == ST_FRAME) begin
          is_err = 1'b1;
        end else begin
          ln_byte[0]  = CH_START;
          ln_ctrl[0]  = 1'b1;
          ln_start[0] = 1'b1;
          dec_state   = ST_FRAME;
        end
      end
      BK_START4: begin
        if (state == ST_FRAME) begin
          is_err = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            ln_byte[i] = CH_IDLE;
            ln_ctrl[i] = 1'b1;
            ln_idle[i] = 1'b1;
          end
          ln_byte[4]  = CH_START;
          ln_ctrl[4]  = 1'b1;
          ln_start[4] = 1'b1;
          dec_state   = ST_FRAME;
        end
      end
      BK_TERM: begin
        if (state == ST_IDLE) begin
          is_err = 1'b1;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (i < int'(term_k)) begin
              ln_byte[i] = tail[8*i +: 8];
            end else if (i == int'(term_k)) begin
              ln_byte[i] = CH_TERM;
              ln_ctrl[i] = 1'b1;
              ln_term[i] = 1'b1;
            end else begin
              ln_byte[i] = CH_IDLE;
              ln_ctrl[i] = 1'b1;
              ln_idle[i] = 1'b1;
            end
          end
          dec_state = ST_IDLE;
        end
      end
      default: is_err = 1'b1;
    endcase

    if (is_err) begin
      ln_byte   = {8{CH_IDLE}};
      ln_ctrl   = '1;
      ln_idle   = '1;
      ln_start  = '0;
      ln_term   = '0;
      ln_cancel = '0;
      if (state == ST_FRAME) begin
        ln_byte[0]   = CH_ERR;
        ln_idle[0]   = 1'b0;
        ln_cancel[0] = 1'b1;
      end
      dec_state = ST_IDLE;
    end

    state_nxt = accept ? dec_state : state;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  logic [SLICE_N-1:0][DATA_W-1:0]      sl_data, buf_data;
  logic [SLICE_N-1:0]                  sl_ctrl, sl_idle, sl_term, sl_cancel;
  logic [SLICE_N-1:0]                  buf_ctrl, buf_idle, buf_term, buf_cancel;
  logic [SLICE_N-1:0][LANE0_CNT_N-1:0] sl_start, buf_start;
  logic [SLICE_N-1:0][KEEP_W-1:0]      sl_keep, buf_keep;

  assign sl_data = ln_byte;

  generate
    for (genvar s = 0; s < SLICE_N; s++) begin : g_slice
      pcs_rx_dec_slice #(
        .KEEP_W      (KEEP_W),
        .LANE0_CNT_N (LANE0_CNT_N)
      ) u_slice (
        .ln_ctrl   (ln_ctrl[s*KEEP_W +: KEEP_W]),
        .ln_idle   (ln_idle[s*KEEP_W +: KEEP_W]),
        .ln_start  (ln_start[s*KEEP_W +: KEEP_W]),
        .ln_term   (ln_term[s*KEEP_W +: KEEP_W]),
        .ln_cancel (ln_cancel[s*KEEP_W +: KEEP_W]),
        .ctrl_v    (sl_ctrl[s]),
        .idle      (sl_idle[s]),
        .start     (sl_start[s]),
        .term      (sl_term[s]),
        .keep      (sl_keep[s]),
        .cancel    (sl_cancel[s])
      );
    end
  endgenerate

  assign last        = (idx == IDX_W'(SLICE_N - 1));
  assign blk_ready_o = !mac_valid_o || last;
  assign accept      = blk_valid_i && blk_ready_o;
  assign idx_nxt     = idx + 1'b1;

  // Slice 0 goes straight from the decoder to the output; later slices replay from the buffer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx             <= '0;
      buf_data        <= '0;
      buf_ctrl        <= '0;
      buf_idle        <= '0;
      buf_term        <= '0;
      buf_cancel      <= '0;
      buf_start       <= '0;
      buf_keep        <= '0;
      mac_valid_o     <= 1'b0;
      mac_cancel_o    <= 1'b0;
      mac_data_o      <= '0;
      mac_ctrl_v_o    <= 1'b0;
      mac_idle_o      <= 1'b0;
      mac_start_o     <= '0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;
    end else if (accept) begin
      idx             <= '0;
      buf_data        <= sl_data;
      buf_ctrl        <= sl_ctrl;
      buf_idle        <= sl_idle;
      buf_term        <= sl_term;
      buf_cancel      <= sl_cancel;
      buf_start       <= sl_start;
      buf_keep        <= sl_keep;
      mac_valid_o     <= 1'b1;
      mac_cancel_o    <= sl_cancel[0];
      mac_data_o      <= sl_data[0];
      mac_ctrl_v_o    <= sl_ctrl[0];
      mac_idle_o      <= sl_idle[0];
      mac_start_o     <= sl_start[0];
      mac_term_o      <= sl_term[0];
      mac_term_keep_o <= sl_keep[0];
    end else if (mac_valid_o && !last) begin
      idx             <= idx_nxt;
      mac_valid_o     <= 1'b1;
      mac_cancel_o    <= buf_cancel[idx_nxt];
      mac_data_o      <= buf_data[idx_nxt];
      mac_ctrl_v_o    <= buf_ctrl[idx_nxt];
      mac_idle_o      <= buf_idle[idx_nxt];
      mac_start_o     <= buf_start[idx_nxt];
      mac_term_o      <= buf_term[idx_nxt];
      mac_term_keep_o <= buf_keep[idx_nxt];
    end else begin
      idx             <= '0;
      mac_valid_o     <= 1'b0;
      mac_cancel_o    <= 1'b0;
      mac_data_o      <= '0;
      mac_ctrl_v_o    <= 1'b0;
      mac_idle_o      <= 1'b0;
      mac_start_o     <= '0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;
    end
  end

`ifdef PCS_RX_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                                        err_cnt_o <= '0;
    else if (accept && is_err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pcs_rx_dec.sv
// tb_pcs_rx_dec: directed-vector bench for pcs_rx_dec at DATA_W=16 with hand-computed slices.
module tb_pcs_rx_dec;
  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [1:0]  blk_sync = 2'b00;
  logic [63:0] blk_data = '0;
  logic        mac_valid, mac_cancel, mac_ctrl_v, mac_idle, mac_term;
  logic [15:0] mac_data;
  logic [0:0]  mac_start;
  logic [1:0]  mac_keep;
`ifdef PCS_RX_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int vcnt   = 0;

  logic [15:0] cd [4];
  logic        cv [4], cc [4], ci [4], cs [4], ct [4], cx [4], cr [4];
  logic [1:0]  ck [4];

  pcs_rx_dec #(.DATA_W(16)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .blk_valid_i     (blk_valid),
    .blk_ready_o     (blk_ready),
    .blk_sync_i      (blk_sync),
    .blk_data_i      (blk_data),
    .mac_valid_o     (mac_valid),
    .mac_cancel_o    (mac_cancel),
    .mac_data_o      (mac_data),
    .mac_ctrl_v_o    (mac_ctrl_v),
    .mac_idle_o      (mac_idle),
    .mac_start_o     (mac_start),
    .mac_term_o      (mac_term),
    .mac_term_keep_o (mac_keep)
`ifdef PCS_RX_DEC_ERR_CNT_EN
    ,
    .err_cnt_o       (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Present one block, capture its four slices, and check the valid/ready cadence.
  task automatic run_blk(input string nm, input logic [1:0] sy, input logic [63:0] d);
    blk_sync  = sy;
    blk_data  = d;
    blk_valid = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      cv[s] = mac_valid;  cd[s] = mac_data;   cc[s] = mac_ctrl_v; ci[s] = mac_idle;
      cs[s] = mac_start[0]; ct[s] = mac_term; ck[s] = mac_keep;   cx[s] = mac_cancel;
      cr[s] = blk_ready;
      if (mac_valid) vcnt++;
      chk($sformatf("%s.vld%0d", nm, s), cv[s], 1'b1);
      chk($sformatf("%s.rdy%0d", nm, s), cr[s], (s == 3));
    end
    blk_valid = 1'b0;
  endtask

  task automatic chk_idle_blk(input string nm);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s.idle%0d", nm, s), ci[s], 1'b1);
      chk($sformatf("%s.ctrl%0d", nm, s), cc[s], 1'b1);
      chk($sformatf("%s.cancel%0d", nm, s), cx[s], 1'b0);
    end
  endtask

  task automatic chk_out_zero(input string nm);
    chk({nm, ".valid"}, mac_valid, 1'b0);
    chk({nm, ".data"}, mac_data, 16'h0);
    chk({nm, ".ctrl"}, mac_ctrl_v, 1'b0);
    chk({nm, ".idle"}, mac_idle, 1'b0);
    chk({nm, ".start"}, mac_start, 1'b0);
    chk({nm, ".term"}, mac_term, 1'b0);
    chk({nm, ".keep"}, mac_keep, 2'b00);
    chk({nm, ".cancel"}, mac_cancel, 1'b0);
    chk({nm, ".ready"}, blk_ready, 1'b1);
`ifdef PCS_RX_DEC_ERR_CNT_EN
    chk({nm, ".errcnt"}, err_cnt, 16'd0);
`endif
  endtask

  initial begin
    #2 nreset = 1'b0;
    #1 chk_out_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    @(negedge clk);

    // start lane 0: 78 55 55 55 55 55 55 D5
    run_blk("st0", 2'b10, 64'hD5555555_55555578);
    chk("st0.d0", cd[0], 16'h5555); chk("st0.s0", cs[0], 1'b1); chk("st0.c0", cc[0], 1'b1);
    chk("st0.d1", cd[1], 16'h5555); chk("st0.d2", cd[2], 16'h5555); chk("st0.d3", cd[3], 16'hD555);
    for (int s = 1; s < 4; s++) begin
      chk($sformatf("st0.c%0d", s), cc[s], 1'b0);
      chk($sformatf("st0.s%0d", s), cs[s], 1'b0);
    end

    // T3: B4 11 22 33 ...
    run_blk("t3", 2'b10, 64'h77665544_332211B4);
    chk("t3.d0", cd[0], 16'h2211); chk("t3.c0", cc[0], 1'b0); chk("t3.t0", ct[0], 1'b0);
    chk("t3.t1", ct[1], 1'b1); chk("t3.k1", ck[1], 2'b01); chk("t3.c1", cc[1], 1'b1);
    chk("t3.d1lo", cd[1][7:0], 8'h33);
    chk("t3.i2", ci[2], 1'b1); chk("t3.i3", ci[3], 1'b1); chk("t3.t2", ct[2], 1'b0);

    // sync 11 inside a frame cancels
    run_blk("st0b", 2'b10, 64'hD5555555_55555578);
    chk("st0b.s0", cs[0], 1'b1);
`ifdef PCS_RX_DEC_ERR_CNT_EN
    chk("err.cnt0", err_cnt, 16'd0);
`endif
    run_blk("e11", 2'b11, 64'h0);
    chk("e11.x0", cx[0], 1'b1); chk("e11.c0", cc[0], 1'b1);
    for (int s = 1; s < 4; s++) begin
      chk($sformatf("e11.x%0d", s), cx[s], 1'b0);
      chk($sformatf("e11.i%0d", s), ci[s], 1'b1);
    end
`ifdef PCS_RX_DEC_ERR_CNT_EN
    chk("err.cnt1", err_cnt, 16'd1);
`endif

    // data block outside a frame: all idle, no cancel
    run_blk("dio", 2'b01, 64'h01234567_89ABCDEF);
    chk_idle_blk("dio");

    // start lane 4: 33 AA BB CC DD 55 55 D5
    run_blk("st4", 2'b10, 64'hD55555DD_CCBBAA33);
    chk("st4.i0", ci[0], 1'b1); chk("st4.i1", ci[1], 1'b1);
    chk("st4.s0", cs[0], 1'b0); chk("st4.s1", cs[1], 1'b0);
    chk("st4.s2", cs[2], 1'b1); chk("st4.d2", cd[2], 16'h5555); chk("st4.c2", cc[2], 1'b1);
    chk("st4.d3", cd[3], 16'hD555); chk("st4.c3", cc[3], 1'b0);

    // start while in frame: cancel, new frame dropped
    run_blk("sif", 2'b10, 64'hD5555555_55555578);
    chk("sif.x0", cx[0], 1'b1); chk("sif.s0", cs[0], 1'b0);
    chk("sif.i1", ci[1], 1'b1); chk("sif.i3", ci[3], 1'b1);
`ifdef PCS_RX_DEC_ERR_CNT_EN
    chk("err.cnt3", err_cnt, 16'd3);
`endif

    // no block offered when one is due
    @(posedge clk); #1;
    chk("gap.valid", mac_valid, 1'b0);
    chk("gap.cancel", mac_cancel, 1'b0);
    chk("gap.ready", blk_ready, 1'b1);

    // back-to-back start, 3 data, T7
    vcnt = 0;
    run_blk("b2b.s", 2'b10, 64'hD5555555_55555578);
    run_blk("b2b.d1", 2'b01, 64'h11111111_11111111);
    run_blk("b2b.d2", 2'b01, 64'h22222222_22222222);
    run_blk("b2b.d3", 2'b01, 64'h33333333_33333333);
    chk("b2b.d3.d0", cd[0], 16'h3333); chk("b2b.d3.c0", cc[0], 1'b0);
    run_blk("b2b.t7", 2'b10, 64'h07060504_030201FF);
    chk("t7.d0", cd[0], 16'h0201); chk("t7.d1", cd[1], 16'h0403); chk("t7.d2", cd[2], 16'h0605);
    chk("t7.c0", cc[0], 1'b0); chk("t7.t2", ct[2], 1'b0);
    chk("t7.t3", ct[3], 1'b1); chk("t7.k3", ck[3], 2'b01); chk("t7.d3lo", cd[3][7:0], 8'h07);
    chk("b2b.vcnt", vcnt, 20);

    // reset while slice 1 of a data block is on the output
    run_blk("rs.s", 2'b10, 64'hD5555555_55555578);
    blk_sync = 2'b01; blk_data = 64'hA5A5A5A5_A5A5A5A5; blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    @(posedge clk); #1;
    chk("rs.mid.valid", mac_valid, 1'b1);
    chk("rs.mid.data", mac_data, 16'hA5A5);
    nreset = 1'b0;
    #1 chk_out_zero("rs");
    @(posedge clk); #1 chk_out_zero("rs.edge");
    @(negedge clk) nreset = 1'b1;
    @(negedge clk);
    run_blk("rs.idl", 2'b10, 64'h00000000_0000001E);
    chk_idle_blk("rs.idl");

    @(posedge clk); #1;
    chk("end.valid", mac_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary, %0d of %0d passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/pcs_rx_dec.md
# pcs_rx_dec

Receive-side 64b/66b block decoder and width adapter that sits directly upstream of `eth_rx`. It accepts descrambled 66-bit blocks (2-bit sync header plus 64-bit payload) from the PCS lock/descramble stage. It classifies each block per 10GBASE-R block types and serializes it into `DATA_W`-wide slices on the `mac_*` interface consumed by `eth_rx`. Framing errors are reported as a frame cancel.

## Interface
- `DATA_W`, 16, output slice width; legal values 16, 32, 64; `SLICE_N = 64/DATA_W` slices per block
- `KEEP_W`, `DATA_W/8`, byte-enable width
- `LANE0_CNT_N`, `(DATA_W==64)?2:1`, start-flag width

Ports:
- `clk`  in  1  single clock
- `nreset`  in  1  asynchronous, active-low reset
- `blk_valid_i`  in  1  block present
- `blk_ready_o`  out  1  block accepted when `blk_valid_i & blk_ready_o`
- `blk_sync_i`  in  2  sync header; 2'b01 data, 2'b10 control
- `blk_data_i`  in  64  payload; octet n at bits [8n+7:8n], octet 0 = lane 0 / block type
- `mac_valid_o`  out  1  slice valid
- `mac_cancel_o`  out  1  abort current frame
- `mac_data_o`  out  `DATA_W`  slice bytes, lane order
- `mac_ctrl_v_o`  out  1  slice carries control
- `mac_idle_o`  out  1  slice all idle
- `mac_start_o`  out  `LANE0_CNT_N`  start in slice; for `DATA_W`=64, bit0 = lane 0, bit1 = lane 4
- `mac_term_o`  out  1  terminate in slice
- `mac_term_keep_o`  out  `KEEP_W`  valid data bytes in term slice, LSB-packed

## Operation
- Frame FSM:
  - IDLE (outside frame, reset state) and FRAME.
  - Start block: IDLE->FRAME.
  - Terminate block: FRAME->IDLE.
  - Error block: any state -> IDLE.
- Block classification:
  - sync 01 -> data.
  - sync 10 -> decode type from octet 0:
    - 0x1E -> idle.
    - 0x78 -> start, lane 0.
    - 0x33 -> start, lane 4.
    - 0x87/0x99/0xAA/0xB4/0xCC/0xD2/0xE1/0xFF -> terminate, k = 0..7 data bytes.
  - Sync 00/11, or any other type, -> error.
- Data block in FRAME: all slices data, `mac_ctrl_v_o`=0.
- Data block in IDLE: error.
- Idle block: every slice `mac_ctrl_v_o`=1, `mac_idle_o`=1, data don't-care.
- Start lane 0:
  - Lane 0 (/S/) presented as 0x55; lanes 1-7 are payload octets 1-7.
  - Start flag on slice 0; that slice has `mac_ctrl_v_o`=1; remaining slices are data.
- Start lane 4:
  - Lanes 0-3 idle; lane 4 presented as 0x55; lanes 5-7 are octets 5-7.
  - Start flag on the slice containing lane 4 (slice 2 at `DATA_W`=16, slice 1 at `DATA_W`=32, bit1 at `DATA_W`=64).
  - Earlier slices are idle.
- Terminate Tk:
  - Data lane i comes from octet i+1, for i<k.
  - Slices wholly below lane k are data with `mac_ctrl_v_o`=0.
  - The slice containing lane k has `mac_term_o`=1, `mac_ctrl_v_o`=1, `mac_term_keep_o` = (1<<(k mod `KEEP_W`))-1.
  - Later slices are idle.
- Error block:
  - In FRAME: slice 0 has `mac_cancel_o`=1, `mac_ctrl_v_o`=1; remaining slices idle.
  - In IDLE: all slices idle, no cancel.
- Start block received in FRAME: treated as error (cancel, whole block presented idle, FSM->IDLE); the new frame is dropped.

## Timing
- Block accepted at cycle t -> slice 0 registered out at t+1; slice s at t+1+s.
- `blk_ready_o` = buffer empty OR last slice on output this cycle; combinational from registered state; no bubble between back-to-back blocks.
- `blk_valid_i` low when a new block is due: `mac_valid_o`=0, FSM state held, no cancel.
- All control flags are qualified by `mac_valid_o`.
- Reset values:
  - all `mac_*` outputs 0;
  - `blk_ready_o`=1;
  - slice counter 0; FSM IDLE; buffer empty.
- Reset mid-block discards the remaining slices; no cancel is emitted.

## Configuration
- `PCS_RX_DEC_ERR_CNT_EN` defined: adds output `err_cnt_o` [15:0].
  - Increments once per error block (any state), including a start received in FRAME.
  - Saturates at 0xFFFF; reset 0.
- Not defined: port and counter absent; decode behaviour identical.

## Test plan
- `DATA_W`=16, sync 10, payload octets 78 55 55 55 55 55 55 D5:
  - slice0 data 16'h5555, start=1, ctrl_v=1;
  - slices 1-3 = 5555, 5555, D555, ctrl_v=0;
  - FSM FRAME.
- In FRAME, sync 10, octets B4 11 22 33 ..:
  - slice0 16'h2211, ctrl_v=0;
  - slice1 term=1, keep=2'b01, data[7:0]=0x33;
  - slices 2-3 idle=1; FSM IDLE.
- In FRAME, sync 2'b11 block:
  - slice0 cancel=1;
  - slices 1-3 idle;
  - `err_cnt_o` 0->1 with macro enabled.
- Start lane 4 block 33 xx xx xx xx 55 55 D5 (shorthand for the 0x33 start-lane-4 block type, lanes 1-3 don't-care, lanes 4-7 carrying 55 55 55 D5):
  - slices 0-1 idle;
  - slice2 start=1, data 16'h5555;
  - slice3 16'hD555.
- Back-to-back start, 3 data, T7 blocks with `blk_valid_i` held high:
  - 20 consecutive valid slices;
  - `blk_ready_o` high every 4th cycle;
  - term keep=2'b01 on slice 3 of the T7 block.
- Reset asserted on slice 1 of a data block:
  - all outputs 0 next edge, `blk_ready_o`=1;
  - following idle block decoded cleanly, no cancel.
